// File: rtl/mem_wb_hilo.sv
// MEM/WB pipeline register with architectural HI/LO and LLbit state.
// Also keeps a wrapping count of instructions retired through WB.
module mem_wb_hilo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic              mem_wreg,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_whilo,
    input  logic [DATA_W-1:0] mem_hi,
    input  logic [DATA_W-1:0] mem_lo,
    input  logic              mem_llbit_we,
    input  logic              mem_llbit_value,
    output logic [ADDR_W-1:0] wb_wd,
    output logic              wb_wreg,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              wb_whilo,
    output logic [DATA_W-1:0] wb_hi,
    output logic [DATA_W-1:0] wb_lo,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              llbit_o,
    output logic [31:0]       retire_cnt
);

    localparam int unsigned CNT_W = 32;

    logic              wb_valid;
    logic              wb_llbit_we;
    logic              wb_llbit_value;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic              llbit_q;

    logic bubble_c;
    logic load_c;
    logic wb_go_c;

    // Only the MEM and WB stall bits concern this stage.
    logic unused_stall;
    assign unused_stall = &{1'b0, stall[3:0]};

    always_comb begin
        bubble_c = flush | (stall[4] & ~stall[5]);
        load_c   = ~stall[4];
        wb_go_c  = ~stall[5];
    end

    // WB slot: flush wins, a MEM-stalled but WB-advancing slot becomes a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid       <= 1'b0;
            wb_wd          <= '0;
            wb_wreg        <= 1'b0;
            wb_wdata       <= '0;
            wb_whilo       <= 1'b0;
            wb_hi          <= '0;
            wb_lo          <= '0;
            wb_llbit_we    <= 1'b0;
            wb_llbit_value <= 1'b0;
        end else if (bubble_c) begin
            wb_valid       <= 1'b0;
            wb_wd          <= '0;
            wb_wreg        <= 1'b0;
            wb_wdata       <= '0;
            wb_whilo       <= 1'b0;
            wb_hi          <= '0;
            wb_lo          <= '0;
            wb_llbit_we    <= 1'b0;
            wb_llbit_value <= 1'b0;
        end else if (load_c) begin
            wb_valid       <= mem_valid;
            wb_wd          <= mem_wd;
            wb_wreg        <= mem_wreg;
            wb_wdata       <= mem_wdata;
            wb_whilo       <= mem_whilo;
            wb_hi          <= mem_hi;
            wb_lo          <= mem_lo;
            wb_llbit_we    <= mem_llbit_we;
            wb_llbit_value <= mem_llbit_value;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (wb_whilo && wb_go_c) begin
            hi_q <= wb_hi;
            lo_q <= wb_lo;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            llbit_q <= 1'b0;
        end else if (flush) begin
            llbit_q <= 1'b0;
        end else if (wb_llbit_we && wb_go_c) begin
            llbit_q <= wb_llbit_value;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_cnt <= '0;
        end else if (wb_valid && wb_go_c && !flush) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

    // Forward the in-flight WB values so readers see them in the same cycle.
    assign hi_o    = wb_whilo ? wb_hi : hi_q;
    assign lo_o    = wb_whilo ? wb_lo : lo_q;
    assign llbit_o = (wb_llbit_we && !flush) ? wb_llbit_value : llbit_q;

endmodule
